// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out receiver.
package sipo_pkg;

    // Receive FSM: IDLE waits for a frame start, RECV is collecting bits of a word.
    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    // Width of the bit counter needed to index WIDTH bits.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_out_stage.sv
// One-word output holding register with a valid/ready handshake.
// A word arriving while the held word is still unaccepted is dropped and
// reported with a single-cycle overrun pulse.
module sipo_out_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word,
    input  logic             word_done,
    input  logic             pout_ready,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    output logic             overrun
);

    logic accept;

    // The buffer can take a new word when empty or when it is being emptied this cycle.
    always_comb begin
        accept = !pout_valid || pout_ready;
    end

    // Load, release or hold the output word; flag dropped words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pout       <= '0;
            pout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (word_done) begin
                if (accept) begin
                    pout       <= word;
                    pout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (pout_valid && pout_ready) begin
                pout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: frames a bit-enabled serial stream into
// WIDTH-bit words and hands them to a one-word valid/ready output buffer.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MSB_FIRST  = 1,
    parameter int CONTINUOUS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             frame_start,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    rx_state_t        state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shift_src;
    logic [WIDTH-1:0] shifted;
    logic             word_done;

    // Next shift-register value; a frame start shifts into a cleared register so
    // the discarded partial word never leaks into the realigned one.
    always_comb begin
        shift_src = frame_start ? '0 : sreg;
        if (MSB_FIRST != 0) begin
            shifted = {shift_src[WIDTH-2:0], sin};
        end else begin
            shifted = {sin, shift_src[WIDTH-1:1]};
        end
        // Realignment on the completion edge wins over completing the word.
        word_done = (state == RECV) && sin_en && !frame_start && (cnt == LAST);
    end

    // Receive FSM with the shift register and bit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            if (frame_start) begin
                state <= RECV;
                if (sin_en) begin
                    sreg <= shifted;
                    cnt  <= CW'(1);
                end else begin
                    sreg <= '0;
                    cnt  <= '0;
                end
            end else if ((state == RECV) && sin_en) begin
                sreg <= shifted;
                if (cnt == LAST) begin
                    cnt <= '0;
                    if (CONTINUOUS == 0) begin
                        state <= IDLE;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign busy = (state == RECV);

    sipo_out_stage #(
        .WIDTH(WIDTH)
    ) u_out (
        .clk        (clk),
        .rst        (rst),
        .word       (shifted),
        .word_done  (word_done),
        .pout_ready (pout_ready),
        .pout       (pout),
        .pout_valid (pout_valid),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_sipo_rx.sv
// Testbench for sipo_rx: three instances (default, CONTINUOUS=1, MSB_FIRST=0)
// driven by directed words; a monitor scores every handshake against a queue.
module tb_sipo_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        sin    [3];
    logic        sin_en [3];
    logic        fs     [3];
    logic        rdy    [3];
    logic [15:0] pout   [3];
    logic        pv     [3];
    logic        busy   [3];
    logic        ovr    [3];

    int tests = 0;
    int fails = 0;
    int hs_cnt  [3];
    int ovr_cnt [3];

    logic [15:0] expq0[$];
    logic [15:0] expq1[$];
    logic [15:0] expq2[$];

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(16), .MSB_FIRST(1), .CONTINUOUS(0)) u_dflt (
        .clk(clk), .rst(rst), .sin(sin[0]), .sin_en(sin_en[0]), .frame_start(fs[0]),
        .pout(pout[0]), .pout_valid(pv[0]), .pout_ready(rdy[0]), .busy(busy[0]), .overrun(ovr[0]));

    sipo_rx #(.WIDTH(16), .MSB_FIRST(1), .CONTINUOUS(1)) u_cont (
        .clk(clk), .rst(rst), .sin(sin[1]), .sin_en(sin_en[1]), .frame_start(fs[1]),
        .pout(pout[1]), .pout_valid(pv[1]), .pout_ready(rdy[1]), .busy(busy[1]), .overrun(ovr[1]));

    sipo_rx #(.WIDTH(16), .MSB_FIRST(0), .CONTINUOUS(0)) u_lsb (
        .clk(clk), .rst(rst), .sin(sin[2]), .sin_en(sin_en[2]), .frame_start(fs[2]),
        .pout(pout[2]), .pout_valid(pv[2]), .pout_ready(rdy[2]), .busy(busy[2]), .overrun(ovr[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pop_and_check(input int i, input logic [15:0] got);
        logic [15:0] e;
        bit          empty;
        empty = 1'b0;
        e     = '0;
        case (i)
            0: if (expq0.size() == 0) empty = 1'b1; else e = expq0.pop_front();
            1: if (expq1.size() == 0) empty = 1'b1; else e = expq1.pop_front();
            default: if (expq2.size() == 0) empty = 1'b1; else e = expq2.pop_front();
        endcase
        tests++;
        if (empty) begin
            fails++;
            $display("FAIL unexpected_word[%0d]: got %h, expected no word", i, got);
        end else if (got !== e) begin
            fails++;
            $display("FAIL word[%0d]: got %h, expected %h", i, got, e);
        end
    endtask

    // Monitor: count overrun pulses and score every accepted word.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst === 1'b1) begin
                if (ovr[i] === 1'b1) ovr_cnt[i]++;
                if (pv[i] === 1'b1 && rdy[i] === 1'b1) begin
                    hs_cnt[i]++;
                    pop_and_check(i, pout[i]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one input cycle; returns 1 time unit after the sampling edge.
    task automatic cyc(input int i, input logic b, input logic en, input logic f);
        sin[i]    = b;
        sin_en[i] = en;
        fs[i]     = f;
        @(posedge clk);
        #1;
        sin_en[i] = 1'b0;
        fs[i]     = 1'b0;
        sin[i]    = 1'b0;
    endtask

    // Send a 16-bit word in the order the instance expects (instance 2 is LSB-first).
    task automatic send_word(input int i, input logic [15:0] w, input bit gaps, input bit with_fs);
        logic b;
        for (int k = 0; k < 16; k++) begin
            if (gaps && k > 0) begin
                repeat ($urandom_range(1, 3)) cyc(i, 1'b1, 1'b0, 1'b0);
            end
            b = (i == 2) ? w[k] : w[15 - k];
            cyc(i, b, 1'b1, with_fs && (k == 0));
        end
    endtask

    int h0;
    int o0;

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sin[i] = 1'b0; sin_en[i] = 1'b0; fs[i] = 1'b0; rdy[i] = 1'b0;
            hs_cnt[i] = 0; ovr_cnt[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_pout[%0d]", i), {16'h0, pout[i]}, 32'h0);
            check($sformatf("reset_valid[%0d]", i), {31'h0, pv[i]}, 32'h0);
            check($sformatf("reset_busy[%0d]", i), {31'h0, busy[i]}, 32'h0);
            check($sformatf("reset_overrun[%0d]", i), {31'h0, ovr[i]}, 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();

        // 1: plain MSB-first word, consumer always ready
        rdy[0] = 1'b1;
        expq0.push_back(16'hA5C3);
        send_word(0, 16'hA5C3, 1'b0, 1'b1);
        check("t1_valid_latency", {31'h0, pv[0]}, 32'h1);
        check("t1_pout", {16'h0, pout[0]}, 32'h0000A5C3);
        check("t1_busy_fell", {31'h0, busy[0]}, 32'h0);
        tick();
        check("t1_valid_one_cycle", {31'h0, pv[0]}, 32'h0);

        // 2: same word with enable gaps between bits
        expq0.push_back(16'hA5C3);
        send_word(0, 16'hA5C3, 1'b1, 1'b1);
        check("t2_valid_latency", {31'h0, pv[0]}, 32'h1);
        check("t2_pout", {16'h0, pout[0]}, 32'h0000A5C3);
        tick();

        // 3: continuous reception into a stalled consumer
        rdy[1] = 1'b0;
        expq1.push_back(16'h1234);
        send_word(1, 16'h1234, 1'b0, 1'b1);
        send_word(1, 16'hFFFF, 1'b0, 1'b0);
        tick();
        tick();
        check("t3_overrun_pulses", ovr_cnt[1], 32'd1);
        check("t3_pout_held", {16'h0, pout[1]}, 32'h00001234);
        check("t3_valid_held", {31'h0, pv[1]}, 32'h1);
        check("t3_busy_continuous", {31'h0, busy[1]}, 32'h1);
        rdy[1] = 1'b1;
        tick();
        check("t3_valid_fell", {31'h0, pv[1]}, 32'h0);
        check("t3_handshakes", hs_cnt[1], 32'd1);

        // 4: partial word, realign, full word
        rdy[0] = 1'b1;
        for (int k = 0; k < 7; k++) cyc(0, 1'b1, 1'b1, k == 0);
        check("t4_no_valid_partial", {31'h0, pv[0]}, 32'h0);
        check("t4_busy_partial", {31'h0, busy[0]}, 32'h1);
        h0 = hs_cnt[0];
        o0 = ovr_cnt[0];
        expq0.push_back(16'h00FF);
        send_word(0, 16'h00FF, 1'b0, 1'b1);
        check("t4_valid", {31'h0, pv[0]}, 32'h1);
        check("t4_pout", {16'h0, pout[0]}, 32'h000000FF);
        tick();
        tick();
        check("t4_one_handshake", hs_cnt[0] - h0, 32'd1);
        check("t4_no_overrun", ovr_cnt[0] - o0, 32'd0);

        // 5: asynchronous reset while a word is held and another is partial
        rdy[0] = 1'b0;
        send_word(0, 16'h5A5A, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) cyc(0, 1'b1, 1'b1, k == 0);
        check("t5_held_before_reset", {16'h0, pout[0]}, 32'h00005A5A);
        check("t5_busy_before_reset", {31'h0, busy[0]}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("t5_async_pout", {16'h0, pout[0]}, 32'h0);
        check("t5_async_valid", {31'h0, pv[0]}, 32'h0);
        check("t5_async_busy", {31'h0, busy[0]}, 32'h0);
        check("t5_async_overrun", {31'h0, ovr[0]}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        rdy[0] = 1'b1;
        expq0.push_back(16'h8001);
        send_word(0, 16'h8001, 1'b0, 1'b1);
        check("t5_pout_after_reset", {16'h0, pout[0]}, 32'h00008001);
        tick();

        // 6: LSB-first instance, bits 1,0,0,0 then zeros
        rdy[2] = 1'b1;
        expq2.push_back(16'h0001);
        send_word(2, 16'h0001, 1'b0, 1'b1);
        check("t6_valid", {31'h0, pv[2]}, 32'h1);
        check("t6_pout", {16'h0, pout[2]}, 32'h00000001);
        repeat (3) tick();

        check("end_queue0_empty", expq0.size(), 32'd0);
        check("end_queue1_empty", expq1.size(), 32'd0);
        check("end_queue2_empty", expq2.size(), 32'd0);
        check("end_handshakes0", hs_cnt[0], 32'd4);
        check("end_handshakes2", hs_cnt[2], 32'd1);
        check("end_overrun0", ovr_cnt[0], 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
